// File: rtl/serial_defs.sv
// Shared serial-link encodings: FSM state codes and line levels.
// The matching receiver imports the same definitions.
package serial_defs;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled.
// tick is high on the last count of each bit period.
module bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT) + 1;

    logic [CNT_W-1:0] count;
    logic             last_c;

    assign last_c = (count == CNT_W'(CLKS_PER_BIT - 1));
    assign tick   = en && last_c;

    // Held at zero while disabled so every bit period starts from a clean count
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            count <= '0;
        end else if (last_c) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/piso_serial_tx.sv
// Parallel-in serial-out frame transmitter: start bit, DATA_W bits LSB-first,
// stop bit, each held CLKS_PER_BIT clocks. All outputs are registered.
module piso_serial_tx #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_out,
    output logic              tx_busy,
    output logic              tx_done
);

    import serial_defs::*;

    localparam int unsigned IDX_W = $clog2(DATA_W) + 1;

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic [DATA_W-1:0] shift;
    logic [DATA_W-1:0] shift_next;
    logic [IDX_W-1:0]  bit_idx;
    logic [IDX_W-1:0]  bit_idx_next;
    logic              out_next;
    logic              done_next;
    logic              tick;

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .en  (state != IDLE),
        .tick(tick)
    );

    // State, shift register and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            shift    <= '0;
            bit_idx  <= '0;
            tx_out   <= IDLE_LEVEL;
            tx_ready <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            state    <= state_next;
            shift    <= shift_next;
            bit_idx  <= bit_idx_next;
            tx_out   <= out_next;
            tx_ready <= (state_next == IDLE);
            tx_busy  <= (state_next != IDLE);
            tx_done  <= done_next;
        end
    end

    // Next state; line level is derived from the state being entered so tx_out stays registered
    always_comb begin
        state_next   = state;
        shift_next   = shift;
        bit_idx_next = bit_idx;
        done_next    = 1'b0;
        out_next     = IDLE_LEVEL;

        case (state)
            IDLE: begin
                if (tx_valid && tx_ready) begin
                    state_next   = START;
                    shift_next   = tx_data;
                    bit_idx_next = '0;
                end
            end
            START: begin
                if (tick) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_next = shift >> 1;
                    if (bit_idx == IDX_W'(DATA_W - 1)) begin
                        state_next   = STOP;
                        bit_idx_next = '0;
                    end else begin
                        bit_idx_next = bit_idx + IDX_W'(1);
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        case (state_next)
            START:   out_next = START_BIT;
            DATA:    out_next = shift_next[0];
            STOP:    out_next = STOP_BIT;
            default: out_next = IDLE_LEVEL;
        endcase
    end

endmodule
